bus_arbiter: RTL and testbench

- Round-robin arbiter and master-side multiplexer for the shared system bus.
- Up to NUM_MASTERS bus masters (CPU bus interfaces, DMA) each raise a request. The arbiter grants exactly one owner and routes that owner's address, strobe, direction and write data onto the single slave-side bus. Ready goes back to the owner only; read data is broadcast to all masters.
- Sits between the masters' bus_req/bus_grnt handshake and the slave address decoder.

---
 rtl/bus_arbiter.sv | 272 +++++++++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Round-robin arbiter and master-side multiplexer for the shared system bus.
// Up to NUM_MASTERS masters raise m_req_i; exactly one owner at a time gets
// the bus. The owner's address, strobe, direction and write data are routed
// to the slave side. Slave ready goes back to the owner only, and slave read
// data is broadcast to every master.
//
// Optional feature macro: BUS_ARB_TIMEOUT_EN
//   defined   : a watchdog completes a stalled access with zero data after
//               TIMEOUT_CYC cycles and sets the sticky timeout_o flag.
//   undefined : no watchdog; timeout_o is tied low and an unresponsive slave
//               stalls the bus indefinitely.
//
// Parameters
//   NUM_MASTERS   number of masters, 2..8
//   BUS_ADD_WIDTH word address width
//   BUS_DAT_WIDTH data width
//   TIMEOUT_CYC   watchdog limit in cycles, 1..65535 (watchdog build only)
//
// Ports
//   clk_i          single clock, rising edge
//   rst_n_i        synchronous active-low reset
//   m_req_i        bus request, one bit per master
//   m_addr_i       packed master addresses, master k at slice k
//   m_as_i         address strobe per master
//   m_rw_i         direction per master (1 = read, 0 = write)
//   m_wr_data_i    packed master write data, master k at slice k
//   m_grnt_o       one-hot grant (all zero when idle)
//   m_rdy_o        slave ready, delivered to the owner only
//   m_rd_data_o    slave read data, broadcast to all masters
//   bus_rd_data_i  slave read data
//   bus_rdy_i      slave ready
//   bus_addr_o     owner address
//   bus_as_o       owner strobe
//   bus_rw_o       owner direction (1 while idle)
//   bus_wr_data_o  owner write data
//   busy_o         bus currently owned
//   owner_o        index of the current owner, 0 when idle
//   timeout_o      sticky watchdog flag
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter int NUM_MASTERS   = 4,
    parameter int BUS_ADD_WIDTH = 30,
    parameter int BUS_DAT_WIDTH = 32,
    parameter int TIMEOUT_CYC   = 255
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic [NUM_MASTERS-1:0]               m_req_i,
    input  logic [NUM_MASTERS*BUS_ADD_WIDTH-1:0] m_addr_i,
    input  logic [NUM_MASTERS-1:0]               m_as_i,
    input  logic [NUM_MASTERS-1:0]               m_rw_i,
    input  logic [NUM_MASTERS*BUS_DAT_WIDTH-1:0] m_wr_data_i,
    output logic [NUM_MASTERS-1:0]               m_grnt_o,
    output logic [NUM_MASTERS-1:0]               m_rdy_o,
    output logic [BUS_DAT_WIDTH-1:0]             m_rd_data_o,
    input  logic [BUS_DAT_WIDTH-1:0]             bus_rd_data_i,
    input  logic                                 bus_rdy_i,
    output logic [BUS_ADD_WIDTH-1:0]             bus_addr_o,
    output logic                                 bus_as_o,
    output logic                                 bus_rw_o,
    output logic [BUS_DAT_WIDTH-1:0]             bus_wr_data_o,
    output logic                                 busy_o,
    output logic [$clog2(NUM_MASTERS)-1:0]       owner_o,
    output logic                                 timeout_o
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [IDX_W:0]   idx_ext_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_e;

    // Elaboration-time guard on the supported parameter ranges.
    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 ||
        TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_check
        $error("bus_arbiter: parameter out of supported range");
    end

    // -----------------------------------------------------------------------
    // Registered state
    // -----------------------------------------------------------------------
    state_e state_q, state_d;
    idx_t   owner_q, owner_d;
    idx_t   ptr_q,   ptr_d;     // first master examined by the next search

    // -----------------------------------------------------------------------
    // Unpack the per-master slices so the owner can be selected by index.
    // -----------------------------------------------------------------------
    logic [BUS_ADD_WIDTH-1:0] addr_arr  [NUM_MASTERS];
    logic [BUS_DAT_WIDTH-1:0] wdata_arr [NUM_MASTERS];

    for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
        assign addr_arr[k]  = m_addr_i[k*BUS_ADD_WIDTH +: BUS_ADD_WIDTH];
        assign wdata_arr[k] = m_wr_data_i[k*BUS_DAT_WIDTH +: BUS_DAT_WIDTH];
    end

    // Index following idx, wrapping at NUM_MASTERS (which need not be a
    // power of two).
    function automatic idx_t next_idx(input idx_t idx);
        if (idx == idx_t'(NUM_MASTERS - 1)) begin
            return '0;
        end
        return idx + idx_t'(1);
    endfunction

    // -----------------------------------------------------------------------
    // Round-robin search: examine ptr, ptr+1, ... (mod NUM_MASTERS) and take
    // the first requester. The sum is one bit wider than an index so the
    // wrap compare cannot overflow.
    // -----------------------------------------------------------------------
    logic win_found;
    idx_t win_idx;

    always_comb begin
        idx_ext_t sum;
        idx_t     cand;
        // NOTE: every variable written in a combinational block is given a
        // default first; a path that leaves one unassigned infers a latch.
        win_found = 1'b0;
        win_idx   = '0;
        sum       = '0;
        cand      = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            sum = {1'b0, ptr_q} + idx_ext_t'(i);
            if (sum >= idx_ext_t'(NUM_MASTERS)) begin
                sum = sum - idx_ext_t'(NUM_MASTERS);
            end
            cand = sum[IDX_W-1:0];
            if (!win_found && m_req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. An owner keeps the bus for as long as it requests.
    // When it lets go, any other pending requester takes over at the same
    // edge, so a handover costs no idle cycle. The releasing owner's request
    // is already low, so it can never win its own handover.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_OWNED;
                    owner_d = win_idx;
                    ptr_d   = next_idx(win_idx);
                end
            end
            ST_OWNED: begin
                if (!m_req_i[owner_q]) begin
                    if (win_found) begin
                        owner_d = win_idx;
                        ptr_d   = next_idx(win_idx);
                    end else begin
                        state_d = ST_IDLE;
                        owner_d = '0;
                    end
                end
            end
        endcase
    end

    // NOTE: reset is synchronous, so it appears only inside the clocked
    // branch and never in the sensitivity list.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            // NOTE: registers use non-blocking assignments so every flop
            // samples the values that existed before this edge.
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    logic owned;
    logic owner_as;

    assign owned    = (state_q == ST_OWNED);
    assign owner_as = m_as_i[owner_q];

    // -----------------------------------------------------------------------
    // Watchdog
    // -----------------------------------------------------------------------
    logic wd_fire;   // stalled access is forced to complete this cycle

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int WD_W = 16;

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q, timeout_d;
    logic            owner_change;

    // Leaving OWNED or handing over both count as a change of owner.
    assign owner_change = (state_d != ST_OWNED) || (owner_d != owner_q);

    // wd_cnt_q holds the stalled cycles already seen, so the current
    // stalled cycle is number wd_cnt_q+1; fire when that reaches the limit.
    assign wd_fire = owned && owner_as && !bus_rdy_i &&
                     (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1));

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (!owned || bus_rdy_i || owner_change || wd_fire) begin
            wd_cnt_d = '0;
        end else if (owner_as) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
    end

    assign timeout_d = timeout_q | wd_fire;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign wd_fire   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Output decode. Grant comes purely from registered state; the slave-side
    // signals are a combinational mux of the owner's slice, parked at fixed
    // values while idle.
    // -----------------------------------------------------------------------
    always_comb begin
        m_grnt_o      = '0;
        m_rdy_o       = '0;
        bus_addr_o    = '0;
        bus_as_o      = 1'b0;
        bus_rw_o      = 1'b1;
        bus_wr_data_o = '0;
        if (owned) begin
            m_grnt_o[owner_q] = 1'b1;
            // A transfer being aborted by reset must not see a ready.
            m_rdy_o[owner_q]  = (bus_rdy_i | wd_fire) & rst_n_i;
            bus_addr_o        = addr_arr[owner_q];
            bus_as_o          = owner_as & ~wd_fire;
            bus_rw_o          = m_rw_i[owner_q];
            bus_wr_data_o     = wdata_arr[owner_q];
        end
    end

    // A watchdog completion returns zero data to the stalled owner.
    assign m_rd_data_o = wd_fire ? '0 : bus_rd_data_i;
    assign busy_o      = owned;
    assign owner_o     = owner_q;   // owner_q is cleared whenever IDLE

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//
// Self-checking bench for bus_arbiter (4 masters, TIMEOUT_CYC = 8).
// Inputs change 1 ns after a rising edge; outputs are compared 1 ns later.
// Works with and without BUS_ARB_TIMEOUT_EN defined.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int N      = 4;
    localparam int AW     = 30;
    localparam int DW     = 32;
    localparam int TO_CYC = 8;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    m_req, m_as, m_rw;
    logic [AW-1:0]   tb_addr  [N];
    logic [DW-1:0]   tb_wdata [N];
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wr_data;
    logic [N-1:0]    m_grnt, m_rdy;
    logic [DW-1:0]   m_rd_data, bus_rd_data, bus_wr_data;
    logic            bus_rdy, bus_as, bus_rw, busy, timeout;
    logic [AW-1:0]   bus_addr;
    logic [1:0]      owner;

    for (genvar k = 0; k < N; k++) begin : g_pack
        assign m_addr[k*AW +: AW]    = tb_addr[k];
        assign m_wr_data[k*DW +: DW] = tb_wdata[k];
    end

    bus_arbiter #(
        .NUM_MASTERS  (N),
        .BUS_ADD_WIDTH(AW),
        .BUS_DAT_WIDTH(DW),
        .TIMEOUT_CYC  (TO_CYC)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .m_req_i      (m_req),
        .m_addr_i     (m_addr),
        .m_as_i       (m_as),
        .m_rw_i       (m_rw),
        .m_wr_data_i  (m_wr_data),
        .m_grnt_o     (m_grnt),
        .m_rdy_o      (m_rdy),
        .m_rd_data_o  (m_rd_data),
        .bus_rd_data_i(bus_rd_data),
        .bus_rdy_i    (bus_rdy),
        .bus_addr_o   (bus_addr),
        .bus_as_o     (bus_as),
        .bus_rw_o     (bus_rw),
        .bus_wr_data_o(bus_wr_data),
        .busy_o       (busy),
        .owner_o      (owner),
        .timeout_o    (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: a rotating priority list instead of a pointer.
    // The head of `order` is the highest-priority master.
    // ------------------------------------------------------------------
    int order[$];
    bit mdl_busy;
    int mdl_owner;
    int mdl_stall;
    bit mdl_to;
    bit mdl_fire;

    task automatic model_reset();
        order.delete();
        for (int k = 0; k < N; k++) order.push_back(k);
        mdl_busy  = 1'b0;
        mdl_owner = 0;
        mdl_stall = 0;
        mdl_to    = 1'b0;
        mdl_fire  = 1'b0;
    endtask

    task automatic model_compare(input int cyc);
        logic [N-1:0] e_grnt, e_rdy;
        mdl_fire = TO_EN && mdl_busy && m_as[mdl_owner] && !bus_rdy &&
                   (mdl_stall == TO_CYC - 1);
        e_grnt = mdl_busy ? (N'(1) << mdl_owner) : '0;
        e_rdy  = (mdl_busy && (bus_rdy || mdl_fire)) ? (N'(1) << mdl_owner) : '0;
        check($sformatf("rnd%0d_grnt", cyc),  64'(m_grnt), 64'(e_grnt));
        check($sformatf("rnd%0d_rdy", cyc),   64'(m_rdy),  64'(e_rdy));
        check($sformatf("rnd%0d_busy", cyc),  64'(busy),   64'(mdl_busy));
        check($sformatf("rnd%0d_owner", cyc), 64'(owner),  64'(mdl_busy ? mdl_owner : 0));
        check($sformatf("rnd%0d_addr", cyc),  64'(bus_addr),
              mdl_busy ? 64'(tb_addr[mdl_owner]) : 64'(0));
        check($sformatf("rnd%0d_as", cyc),    64'(bus_as),
              64'(mdl_busy && m_as[mdl_owner] && !mdl_fire));
        check($sformatf("rnd%0d_rw", cyc),    64'(bus_rw),
              mdl_busy ? 64'(m_rw[mdl_owner]) : 64'(1));
        check($sformatf("rnd%0d_wdata", cyc), 64'(bus_wr_data),
              mdl_busy ? 64'(tb_wdata[mdl_owner]) : 64'(0));
        check($sformatf("rnd%0d_rdata", cyc), 64'(m_rd_data),
              mdl_fire ? 64'(0) : 64'(bus_rd_data));
        check($sformatf("rnd%0d_timeout", cyc), 64'(timeout), 64'(mdl_to));
    endtask

    // Advance the model across one rising edge with the current inputs.
    task automatic model_step();
        bit prev_busy;
        int prev_owner;
        int w;
        prev_busy  = mdl_busy;
        prev_owner = mdl_owner;
        if (!mdl_busy || !m_req[mdl_owner]) begin
            w = -1;
            foreach (order[k]) if (w < 0 && m_req[order[k]]) w = order[k];
            if (w >= 0) begin
                mdl_busy  = 1'b1;
                mdl_owner = w;
                while (order[0] != (w + 1) % N) order.push_back(order.pop_front());
            end else begin
                mdl_busy  = 1'b0;
                mdl_owner = 0;
            end
        end
        if (mdl_fire) mdl_to = 1'b1;
        if (!prev_busy || !mdl_busy || mdl_owner != prev_owner || bus_rdy || mdl_fire)
            mdl_stall = 0;
        else if (m_as[prev_owner])
            mdl_stall++;
    endtask

    // ------------------------------------------------------------------
    // Directed arbitration table: request pattern before an edge and the
    // grant/owner/busy expected after it. Starts right after reset.
    // ------------------------------------------------------------------
    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] grnt;
        int           own;
        logic         bsy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [N-1:0] r, input logic [N-1:0] g,
                                input int o, input logic b);
        vec_t v;
        v.req = r; v.grnt = g; v.own = o; v.bsy = b;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench still running at 2000000 ns, limit 2000000 ns");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        logic [N-1:0] r;

        // grant latency, no preemption, handovers, 0/3 handover from ptr 2
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 1'b0));
        vecs.push_back(mk(4'b0100, 4'b0100, 2, 1'b1));
        vecs.push_back(mk(4'b0100, 4'b0100, 2, 1'b1));
        vecs.push_back(mk(4'b0111, 4'b0100, 2, 1'b1));
        vecs.push_back(mk(4'b0011, 4'b0001, 0, 1'b1));
        vecs.push_back(mk(4'b0010, 4'b0010, 1, 1'b1));
        vecs.push_back(mk(4'b1011, 4'b0010, 1, 1'b1));
        vecs.push_back(mk(4'b1001, 4'b1000, 3, 1'b1));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 1'b0));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 1'b0));
        // all four requesting, each releasing after one transfer: 0,1,2,3,0
        vecs.push_back(mk(4'b1111, 4'b0001, 0, 1'b1));
        vecs.push_back(mk(4'b1110, 4'b0010, 1, 1'b1));
        vecs.push_back(mk(4'b1101, 4'b0100, 2, 1'b1));
        vecs.push_back(mk(4'b1011, 4'b1000, 3, 1'b1));
        vecs.push_back(mk(4'b0111, 4'b0001, 0, 1'b1));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 1'b0));
        // single requester regranted only after an idle cycle
        vecs.push_back(mk(4'b0001, 4'b0001, 0, 1'b1));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 1'b0));
        vecs.push_back(mk(4'b0001, 4'b0001, 0, 1'b1));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 1'b0));

        // ---------------- reset state ----------------
        rst_n       = 1'b0;
        m_req       = 4'b1111;
        m_as        = 4'b1111;
        m_rw        = 4'b0000;
        bus_rdy     = 1'b1;
        bus_rd_data = 32'h5555_AAAA;
        for (int k = 0; k < N; k++) begin
            tb_addr[k]  = AW'(32'h0100_0000 + k);
            tb_wdata[k] = 32'hF000_0000 + k;
        end
        tick();
        tick();
        check("rst_grnt",    64'(m_grnt),      64'(0));
        check("rst_rdy",     64'(m_rdy),       64'(0));
        check("rst_busy",    64'(busy),        64'(0));
        check("rst_owner",   64'(owner),       64'(0));
        check("rst_timeout", 64'(timeout),     64'(0));
        check("rst_as",      64'(bus_as),      64'(0));
        check("rst_rw",      64'(bus_rw),      64'(1));
        check("rst_addr",    64'(bus_addr),    64'(0));
        check("rst_wdata",   64'(bus_wr_data), 64'(0));
        check("rst_rdata",   64'(m_rd_data),   64'(32'h5555_AAAA));
        m_req   = '0;
        m_as    = '0;
        m_rw    = '1;
        bus_rdy = 1'b0;
        rst_n   = 1'b1;
        tick();

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            m_req = vecs[i].req;
            tick();
            check($sformatf("vec%0d_grnt", i),  64'(m_grnt), 64'(vecs[i].grnt));
            check($sformatf("vec%0d_owner", i), 64'(owner),  64'(vecs[i].own));
            check($sformatf("vec%0d_busy", i),  64'(busy),   64'(vecs[i].bsy));
        end

        // ---------------- master 2 transfer, ready on 3rd cycle ----------------
        m_as        = 4'b1011;
        m_rw        = 4'b1111;
        tb_addr[2]  = AW'(32'h0A00_0010);
        tb_wdata[2] = 32'h1234_5678;
        m_as[2]     = 1'b1;
        m_rw[2]     = 1'b0;
        bus_rd_data = 32'hCAFE_F00D;
        m_req       = 4'b0100;
        tick();
        for (int c = 1; c <= 3; c++) begin
            bus_rdy = (c == 3);
            #1;
            check($sformatf("xfer_c%0d_grnt", c),  64'(m_grnt),      64'(4'b0100));
            check($sformatf("xfer_c%0d_addr", c),  64'(bus_addr),    64'(32'h0A00_0010));
            check($sformatf("xfer_c%0d_as", c),    64'(bus_as),      64'(1));
            check($sformatf("xfer_c%0d_rw", c),    64'(bus_rw),      64'(0));
            check($sformatf("xfer_c%0d_wdata", c), 64'(bus_wr_data), 64'(32'h1234_5678));
            check($sformatf("xfer_c%0d_rdy", c),   64'(m_rdy),
                  (c == 3) ? 64'(4'b0100) : 64'(0));
            check($sformatf("xfer_c%0d_rdata", c), 64'(m_rd_data),   64'(32'hCAFE_F00D));
            tick();
        end
        m_req   = '0;
        m_as    = '0;
        bus_rdy = 1'b0;
        #1;
        check("xfer_rdy_once", 64'(m_rdy), 64'(0));
        tick();
        check("xfer_idle_grnt", 64'(m_grnt),   64'(0));
        check("xfer_idle_addr", 64'(bus_addr), 64'(0));
        check("xfer_idle_rw",   64'(bus_rw),   64'(1));

        // ---------------- reset while owned and strobing ----------------
        m_req = 4'b0010;
        m_as  = 4'b0010;
        m_rw  = 4'b1101;
        tick();
        check("rstmid_pre_owner", 64'(owner),  64'(1));
        check("rstmid_pre_as",    64'(bus_as), 64'(1));
        check("rstmid_pre_rw",    64'(bus_rw), 64'(0));
        rst_n   = 1'b0;
        bus_rdy = 1'b1;
        tick();
        check("rstmid_grnt",  64'(m_grnt), 64'(0));
        check("rstmid_as",    64'(bus_as), 64'(0));
        check("rstmid_rw",    64'(bus_rw), 64'(1));
        check("rstmid_owner", 64'(owner),  64'(0));
        check("rstmid_rdy",   64'(m_rdy),  64'(0));
        m_req   = '0;
        m_as    = '0;
        m_rw    = '1;
        bus_rdy = 1'b0;
        rst_n   = 1'b1;
        tick();

        // ---------------- unresponsive slave ----------------
        m_req       = 4'b0010;
        m_as        = 4'b0010;
        bus_rd_data = 32'hDEAD_BEEF;
        tick();
        for (int c = 1; c <= 10; c++) begin
            #1;
            check($sformatf("wd_c%0d_rdy", c),     64'(m_rdy),
                  (TO_EN && c == TO_CYC) ? 64'(4'b0010) : 64'(0));
            check($sformatf("wd_c%0d_rdata", c),   64'(m_rd_data),
                  (TO_EN && c == TO_CYC) ? 64'(0) : 64'(32'hDEAD_BEEF));
            check($sformatf("wd_c%0d_as", c),      64'(bus_as),
                  64'(!(TO_EN && c == TO_CYC)));
            check($sformatf("wd_c%0d_timeout", c), 64'(timeout),
                  64'(TO_EN && c > TO_CYC));
            tick();
        end
        m_req = '0;
        m_as  = '0;
        tick();
        check("wd_sticky_timeout", 64'(timeout), 64'(TO_EN));
        check("wd_idle_busy",      64'(busy),    64'(0));

        // ---------------- randomized against the model ----------------
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            r = N'($urandom_range(0, 15));
            if (mdl_busy && $urandom_range(0, 3) != 0) r[mdl_owner] = 1'b1;
            m_req = r;
            m_as  = N'($urandom) | N'($urandom);
            m_rw  = N'($urandom);
            for (int k = 0; k < N; k++) begin
                tb_addr[k]  = AW'($urandom);
                tb_wdata[k] = $urandom;
            end
            bus_rdy     = ($urandom_range(0, 3) == 0);
            bus_rd_data = $urandom;
            #1;
            model_compare(cyc);
            model_step();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
